// File: rtl/aes_key_expand_ctrl.sv
// AES-128 key-schedule sequencer: one round per clock through an external datapath into an NR+1 entry store; start-to-done NR+1 cycles.
// No backpressure: start is honoured only in IDLE, never queued. Optional KEY_REUSE_EN skips re-expanding an already valid key.
module aes_key_expand_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] ks_key,
  output logic [3:0]   ks_rnd,
  input  logic [127:0] ks_next,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic         rk_valid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_FIN    = 2'd2;
  localparam logic [3:0] LAST_RND = 4'(NR);

  logic [1:0]   state;
  logic [3:0]   rnd;
  logic [127:0] work;
  logic [127:0] store [NR+1];
  logic [127:0] rd_mux;
  logic         reuse;
  logic         accept;

`ifdef KEY_REUSE_EN
  assign reuse = rk_valid && (key_in == store[0]);
`else
  assign reuse = 1'b0;
`endif

  assign accept = (state == S_IDLE) && start;
  assign busy   = (state == S_EXPAND);
  assign done   = (state == S_FIN);
  assign ks_key = work;
  assign ks_rnd = busy ? rnd : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rnd      <= 4'd0;
      work     <= '0;
      rk_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (reuse) begin
              state <= S_FIN;
            end else begin
              work     <= key_in;
              rnd      <= 4'd1;
              rk_valid <= 1'b0;
              state    <= S_EXPAND;
            end
          end
        end
        S_EXPAND: begin
          work <= ks_next;
          if (rnd == LAST_RND) begin
            rnd   <= 4'd0;
            state <= S_FIN;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        S_FIN: begin
          rk_valid <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Entry 0 is the cipher key itself; entries 1..NR are filled in round order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) store[i] <= '0;
    end else if (accept && !reuse) begin
      store[0] <= key_in;
    end else if (busy) begin
      for (int i = 1; i <= NR; i++) begin
        if (rnd == 4'(i)) store[i] <= ks_next;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rk_addr == 4'(i)) rd_mux = store[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rk_data <= '0;
    else        rk_data <= rd_mux;
  end

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Bench for aes_key_expand_ctrl: behavioural AES-128 round-key datapath beside two DUTs (NR=10, NR=4), FIPS-197 vectors.
module tb_aes_key_expand_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start, busy, done, rk_valid;
  logic [127:0] key_in, ks_key, ks_next, rk_data;
  logic [3:0]   ks_rnd, rk_addr;
  logic         start4, busy4, done4, rk_valid4;
  logic [127:0] key4, ks_key4, ks_next4, rk_data4;
  logic [3:0]   ks_rnd4, rk_addr4;

  int total = 0;
  int bad   = 0;
  logic [127:0] sb_q[$];

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A4    = 128'hef44a541a8525b7fb671253bdb0bad00;
  localparam logic [127:0] A10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
      4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
      4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rcon(r), 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign ks_next  = key_step(ks_key, ks_rnd);
  assign ks_next4 = key_step(ks_key4, ks_rnd4);

  aes_key_expand_ctrl #(.NR(10)) u10 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy), .done(done),
    .ks_key(ks_key), .ks_rnd(ks_rnd), .ks_next(ks_next), .rk_addr(rk_addr),
    .rk_data(rk_data), .rk_valid(rk_valid));

  aes_key_expand_ctrl #(.NR(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .key_in(key4), .busy(busy4), .done(done4),
    .ks_key(ks_key4), .ks_rnd(ks_rnd4), .ks_next(ks_next4), .rk_addr(rk_addr4),
    .rk_data(rk_data4), .rk_valid(rk_valid4));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an expansion; extra start pulses are raised during cycles pa/pb.
  task automatic launch(input logic [127:0] key, input int pa, input int pb,
                        output int lat, output int bcnt);
    logic [127:0] mk;
    mk = key;
    key_in = key;
    start = 1'b1;
    lat = 0;
    bcnt = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      tick();
      if (busy) begin
        bcnt++;
        check("ks_rnd step", {124'h0, ks_rnd}, 128'(bcnt));
        check("ks_key feed", ks_key, mk);
        mk = key_step(mk, 4'(bcnt));
      end
      if (done) begin
        lat = n;
        check("ks_rnd in fin", {124'h0, ks_rnd}, 128'h0);
      end
      start = (n == pa || n == pb);
    end
    if (lat == 0) begin
      total++;
      bad++;
      $display("FAIL done timeout: no done within 40 cycles");
    end
    if (start) begin
      tick();
      start = 1'b0;
      check("start in fin ignored busy", {127'h0, busy}, 128'h0);
      check("single done", {127'h0, done}, 128'h0);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [127:0] exp, input string nm);
    rk_addr = a;
    sb_q.push_back(exp);
    tick();
    check(nm, rk_data, sb_q.pop_front());
  endtask

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] exp;
  } rd_vec_t;

  rd_vec_t vt [8];
  int lat, bc, exp_lat, exp_bc;

  initial begin
    rst_n = 1'b0; start = 1'b0; key_in = '0; rk_addr = '0;
    start4 = 1'b0; key4 = '0; rk_addr4 = '0;
    vt[0] = '{4'd0, KEY_A};  vt[1] = '{4'd1, A1};     vt[2] = '{4'd10, A10};
    vt[3] = '{4'd11, '0};    vt[4] = '{4'd12, '0};    vt[5] = '{4'd13, '0};
    vt[6] = '{4'd14, '0};    vt[7] = '{4'd15, '0};

    tick(); tick();
    check("reset busy", {127'h0, busy}, 128'h0);
    check("reset done", {127'h0, done}, 128'h0);
    check("reset rk_valid", {127'h0, rk_valid}, 128'h0);
    check("reset ks_key", ks_key, 128'h0);
    check("reset ks_rnd", {124'h0, ks_rnd}, 128'h0);
    check("reset rk_data", rk_data, 128'h0);
    check("reset busy4", {127'h0, busy4}, 128'h0);
    check("reset rk_data4", rk_data4, 128'h0);
    rst_n = 1'b1;

    launch(KEY_A, 3, 11, lat, bc);
    check("fips latency", 128'(lat), 128'd11);
    check("fips busy cycles", 128'(bc), 128'd10);
    check("rk_valid after fin", {127'h0, rk_valid}, 128'h1);
    for (int i = 0; i < 8; i++)
      rd(vt[i].addr, vt[i].exp, $sformatf("rk_data[%0d]", vt[i].addr));

`ifdef KEY_REUSE_EN
    exp_lat = 1;  exp_bc = 0;
`else
    exp_lat = 11; exp_bc = 10;
`endif
    launch(KEY_A, 0, 0, lat, bc);
    check("same-key restart latency", 128'(lat), 128'(exp_lat));
    check("same-key restart busy", 128'(bc), 128'(exp_bc));
    tick();
    check("rk_valid after restart", {127'h0, rk_valid}, 128'h1);
    rd(4'd10, A10, "rk_data[10] after restart");

    launch(KEY_B, 0, 0, lat, bc);
    check("new-key latency", 128'(lat), 128'd11);
    check("new-key busy", 128'(bc), 128'd10);
    rd(4'd10, B10, "keyB rk_data[10]");
    rd(4'd0, KEY_B, "keyB rk_data[0]");

    key_in = KEY_A;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("mid-run ks_rnd", {124'h0, ks_rnd}, 128'd5);
    rst_n = 1'b0;
    #1;
    check("async busy", {127'h0, busy}, 128'h0);
    check("async done", {127'h0, done}, 128'h0);
    check("async ks_rnd", {124'h0, ks_rnd}, 128'h0);
    check("async ks_key", ks_key, 128'h0);
    check("async rk_data", rk_data, 128'h0);
    check("async rk_valid", {127'h0, rk_valid}, 128'h0);
    tick(); tick();
    rst_n = 1'b1;
    rd(4'd0, 128'h0, "store cleared by reset");
    check("rk_valid stays 0", {127'h0, rk_valid}, 128'h0);
    launch(KEY_B, 0, 0, lat, bc);
    check("post-reset latency", 128'(lat), 128'd11);
    rd(4'd10, B10, "post-reset rk_data[10]");

    key4 = KEY_A;
    start4 = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      tick();
      start4 = 1'b0;
      if (done4) lat = n;
    end
    check("nr4 latency", 128'(lat), 128'd5);
    rk_addr4 = 4'd4;
    sb_q.push_back(A4);
    tick();
    check("nr4 rk_data[4]", rk_data4, sb_q.pop_front());
    rk_addr4 = 4'd5;
    sb_q.push_back(128'h0);
    tick();
    check("nr4 rk_data[5] out of range", rk_data4, sb_q.pop_front());
    check("nr4 rk_valid", {127'h0, rk_valid4}, 128'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
